// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the MIPS control units (multicycle and single-cycle):
//   - state_t     : 4-bit multicycle FSM state encoding
//   - OP_*        : primary opcodes (instr[31:26])
//   - FN_*        : R-type funct codes (instr[5:0])
//   - ALU_*       : ALU control encodings driven to the datapath ALU
//   - aluop_t     : 2-bit ALU operation class fed to alu_decoder
//   - is_legal_op : true for every opcode the controllers implement
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEXE = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the multicycle controller and its datapath / memory.
//   Datapath -> controller : op, funct, zero, mem_ready
//   Controller -> datapath : mem_req, memwrite, iord, irwrite, pcen, pcsrc,
//                            alusrca, alusrcb, alucontrol, regdst, memtoreg,
//                            regwrite, illegal, state (debug)
// Memory handshake: mem_req is held high for the whole access; the access
// completes in the cycle where mem_req and mem_ready are both high. mem_ready
// has no meaning while mem_req is low. memwrite is only valid alongside
// mem_req and the write commits on the mem_ready cycle.
// master = controller, slave = datapath.
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, illegal, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, illegal, state
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decode, shared with the single-cycle control unit.
//   i_aluop       : operation class (add / sub / decode from funct)
//   i_funct       : instr[5:0]
//   o_alucontrol  : 3-bit ALU control
// Unknown funct codes fall back to add.
// -----------------------------------------------------------------------------
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alucontrol = ALU_ADD;
                    FN_SUB:  o_alucontrol = ALU_SUB;
                    FN_AND:  o_alucontrol = ALU_AND;
                    FN_OR:   o_alucontrol = ALU_OR;
                    FN_SLT:  o_alucontrol = ALU_SLT;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore-style control FSM for the multicycle MIPS datapath.
//   clk      : rising-edge clock
//   reset    : synchronous, active-low
//   ctrl_bus : multicycle_controller_if.master (decode inputs, memory
//              handshake, datapath controls, debug state)
// Outputs are decoded combinationally from the state register; only
// irwrite/pcen in FETCH (mem_ready) and pcen in BRANCH (zero) look at inputs.
// While reset is low every enable/strobe is forced off so an access that is
// in flight is dropped without a write being signalled.
// -----------------------------------------------------------------------------
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    multicycle_controller_if.master         ctrl_bus
);

    state_t     r_state;

    logic       w_mem_req;
    logic       w_memwrite;
    logic       w_iord;
    logic       w_irwrite;
    logic       w_pcen;
    logic [1:0] w_pcsrc;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_illegal;
    aluop_t     w_aluop;
    logic       w_alu_active;
    logic [2:0] w_alucontrol;

    // State register and next-state logic.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:   if (ctrl_bus.mem_ready) r_state <= DECODE;
                DECODE: begin
                    case (ctrl_bus.op)
                        OP_LW, OP_SW:   r_state <= MEMADR;
                        OP_RTYPE:       r_state <= EXECUTE;
                        OP_BEQ, OP_BNE: r_state <= BRANCH;
                        OP_ADDI:        r_state <= ADDIEXE;
                        OP_J:           r_state <= JUMP;
                        default:        r_state <= FETCH;
                    endcase
                end
                // Only lw/sw reach MEMADR, so anything not sw is a load.
                MEMADR:  r_state <= (ctrl_bus.op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (ctrl_bus.mem_ready) r_state <= MEMWB;
                MEMWB:   r_state <= FETCH;
                MEMWR:   if (ctrl_bus.mem_ready) r_state <= FETCH;
                EXECUTE: r_state <= ALUWB;
                ALUWB:   r_state <= FETCH;
                BRANCH:  r_state <= FETCH;
                ADDIEXE: r_state <= ADDIWB;
                ADDIWB:  r_state <= FETCH;
                JUMP:    r_state <= FETCH;
                default: r_state <= FETCH;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        w_mem_req    = 1'b0;
        w_memwrite   = 1'b0;
        w_iord       = 1'b0;
        w_irwrite    = 1'b0;
        w_pcen       = 1'b0;
        w_pcsrc      = 2'b00;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_regwrite   = 1'b0;
        w_illegal    = 1'b0;
        w_aluop      = ALUOP_ADD;
        w_alu_active = 1'b0;
        case (r_state)
            FETCH: begin
                w_mem_req    = 1'b1;
                w_alusrcb    = 2'b01;
                w_alu_active = 1'b1;
                // IR and PC+4 load together on the cycle the fetch completes.
                w_irwrite    = ctrl_bus.mem_ready;
                w_pcen       = ctrl_bus.mem_ready;
            end
            DECODE: begin
                w_alusrcb    = 2'b11;
                w_alu_active = 1'b1;
                w_illegal    = !is_legal_op(ctrl_bus.op);
            end
            MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_alu_active = 1'b1;
            end
            MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            MEMWR: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            EXECUTE: begin
                w_alusrca    = 1'b1;
                w_aluop      = ALUOP_FUNCT;
                w_alu_active = 1'b1;
            end
            ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            BRANCH: begin
                w_alusrca    = 1'b1;
                w_aluop      = ALUOP_SUB;
                w_alu_active = 1'b1;
                w_pcsrc      = 2'b01;
                w_pcen       = (ctrl_bus.op == OP_BNE) ? !ctrl_bus.zero : ctrl_bus.zero;
            end
            ADDIEXE: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_alu_active = 1'b1;
            end
            ADDIWB: begin
                w_regwrite = 1'b1;
            end
            JUMP: begin
                w_pcsrc = 2'b10;
                w_pcen  = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct      (ctrl_bus.funct),
        .o_alucontrol (w_alucontrol)
    );

    // Enables and strobes are gated by reset; select lines are left as decoded.
    assign ctrl_bus.mem_req    = w_mem_req  & reset;
    assign ctrl_bus.memwrite   = w_memwrite & reset;
    assign ctrl_bus.irwrite    = w_irwrite  & reset;
    assign ctrl_bus.pcen       = w_pcen     & reset;
    assign ctrl_bus.regwrite   = w_regwrite & reset;
    assign ctrl_bus.illegal    = w_illegal  & reset;
    assign ctrl_bus.iord       = w_iord;
    assign ctrl_bus.pcsrc      = w_pcsrc;
    assign ctrl_bus.alusrca    = w_alusrca;
    assign ctrl_bus.alusrcb    = w_alusrcb;
    assign ctrl_bus.regdst     = w_regdst;
    assign ctrl_bus.memtoreg   = w_memtoreg;
    // ALU control reads 000 in states that do not use the ALU.
    assign ctrl_bus.alucontrol = w_alu_active ? w_alucontrol : 3'b000;
    assign ctrl_bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench for multicycle_controller. Each driven cycle pushes the full
// expected output vector; a monitor pops and compares every cycle.
// Vector: {state, mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
//          alusrcb, alucontrol, regdst, memtoreg, regwrite, illegal}
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int W = 21;

    logic clk;
    logic reset;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk      (clk),
        .reset    (reset),
        .ctrl_bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           tests_run    = 0;
    int           tests_failed = 0;

    logic [5:0] cur_op;
    logic [5:0] cur_funct;

    function automatic logic [W-1:0] v(
        input logic [3:0] st, input logic mreq, input logic mw, input logic iord,
        input logic irw, input logic pcen, input logic [1:0] pcsrc,
        input logic asa, input logic [1:0] asb, input logic [2:0] aluc,
        input logic rdst, input logic m2r, input logic rw, input logic ill);
        return {st, mreq, mw, iord, irw, pcen, pcsrc, asa, asb, aluc, rdst, m2r, rw, ill};
    endfunction

    // Hand-written per-state expectations.
    function automatic logic [W-1:0] e_fetch(input logic rdy);
        return v(4'd0, 1, 0, 0, rdy, rdy, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_decode(input logic ill);
        return v(4'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, ill);
    endfunction
    function automatic logic [W-1:0] e_memadr();
        return v(4'd2, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_memrd();
        return v(4'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_memwb();
        return v(4'd4, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1, 0);
    endfunction
    function automatic logic [W-1:0] e_memwr();
        return v(4'd5, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_exec(input logic [2:0] aluc);
        return v(4'd6, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, aluc, 0, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_aluwb();
        return v(4'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 1, 0);
    endfunction
    function automatic logic [W-1:0] e_branch(input logic pcen);
        return v(4'd8, 0, 0, 0, 0, pcen, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_addiexe();
        return v(4'd9, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_addiwb();
        return v(4'd10, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 1, 0);
    endfunction
    function automatic logic [W-1:0] e_jump();
        return v(4'd11, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0, 0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_ir(input logic [5:0] op, input logic [5:0] funct);
        cur_op    = op;
        cur_funct = funct;
    endtask

    task automatic step(input logic rst, input logic rdy, input logic z,
                        input logic [W-1:0] e, input string nm);
        @(negedge clk);
        reset         = rst;
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.op        = cur_op;
        bus.funct     = cur_funct;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp_v;
        string        nm;
        #2;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {bus.state, bus.mem_req, bus.memwrite, bus.iord, bus.irwrite,
                     bus.pcen, bus.pcsrc, bus.alusrca, bus.alusrcb, bus.alucontrol,
                     bus.regdst, bus.memtoreg, bus.regwrite, bus.illegal};
            tests_run++;
            if (act !== exp_v) begin
                tests_failed++;
                $display("FAIL %s: got %b expected %b", nm, act, exp_v);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        bus.op        = 6'b000000;
        bus.funct     = 6'b000000;
        set_ir(6'b000000, 6'b000000);

        // Reset low 3 cycles: FETCH, all enables off.
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, v(4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0), "reset");

        // lw, zero-wait: 5 cycles.
        set_ir(6'b100011, 6'b000000);
        step(1, 1, 0, e_fetch(1), "lw_fetch");
        step(1, 1, 0, e_decode(0), "lw_decode");
        step(1, 1, 0, e_memadr(), "lw_memadr");
        step(1, 1, 0, e_memrd(), "lw_memrd");
        step(1, 1, 0, e_memwb(), "lw_memwb");

        // R-type sub.
        set_ir(6'b000000, 6'b100010);
        step(1, 1, 0, e_fetch(1), "sub_fetch");
        step(1, 1, 0, e_decode(0), "sub_decode");
        step(1, 1, 0, e_exec(3'b110), "sub_exec");
        step(1, 1, 0, e_aluwb(), "sub_aluwb");

        // R-type slt.
        set_ir(6'b000000, 6'b101010);
        step(1, 1, 0, e_fetch(1), "slt_fetch");
        step(1, 1, 0, e_decode(0), "slt_decode");
        step(1, 1, 0, e_exec(3'b111), "slt_exec");
        step(1, 1, 0, e_aluwb(), "slt_aluwb");

        // R-type and / or / unknown funct (falls back to add, no illegal).
        set_ir(6'b000000, 6'b100100);
        step(1, 1, 0, e_fetch(1), "and_fetch");
        step(1, 1, 0, e_decode(0), "and_decode");
        step(1, 1, 0, e_exec(3'b000), "and_exec");
        step(1, 1, 0, e_aluwb(), "and_aluwb");
        set_ir(6'b000000, 6'b100101);
        step(1, 1, 0, e_fetch(1), "or_fetch");
        step(1, 1, 0, e_decode(0), "or_decode");
        step(1, 1, 0, e_exec(3'b001), "or_exec");
        step(1, 1, 0, e_aluwb(), "or_aluwb");
        set_ir(6'b000000, 6'b111111);
        step(1, 1, 0, e_fetch(1), "badfn_fetch");
        step(1, 1, 0, e_decode(0), "badfn_decode");
        step(1, 1, 0, e_exec(3'b010), "badfn_exec");
        step(1, 1, 0, e_aluwb(), "badfn_aluwb");

        // addi.
        set_ir(6'b001000, 6'b000000);
        step(1, 1, 0, e_fetch(1), "addi_fetch");
        step(1, 1, 0, e_decode(0), "addi_decode");
        step(1, 1, 0, e_addiexe(), "addi_exe");
        step(1, 1, 0, e_addiwb(), "addi_wb");

        // beq zero=1 (taken), bne zero=1 (not taken), bne zero=0 (taken).
        set_ir(6'b000100, 6'b000000);
        step(1, 1, 1, e_fetch(1), "beq_fetch");
        step(1, 1, 1, e_decode(0), "beq_decode");
        step(1, 1, 1, e_branch(1), "beq_branch_z1");
        set_ir(6'b000101, 6'b000000);
        step(1, 1, 1, e_fetch(1), "bne_fetch");
        step(1, 1, 1, e_decode(0), "bne_decode");
        step(1, 1, 1, e_branch(0), "bne_branch_z1");
        step(1, 1, 0, e_fetch(1), "bne2_fetch");
        step(1, 1, 0, e_decode(0), "bne2_decode");
        step(1, 1, 0, e_branch(1), "bne_branch_z0");

        // j with two fetch wait cycles.
        set_ir(6'b000010, 6'b000000);
        step(1, 0, 0, e_fetch(0), "j_fetch_wait1");
        step(1, 0, 0, e_fetch(0), "j_fetch_wait2");
        step(1, 1, 0, e_fetch(1), "j_fetch");
        step(1, 1, 0, e_decode(0), "j_decode");
        step(1, 1, 0, e_jump(), "j_jump");

        // lw with one MEMRD wait cycle.
        set_ir(6'b100011, 6'b000000);
        step(1, 1, 0, e_fetch(1), "lw2_fetch");
        step(1, 1, 0, e_decode(0), "lw2_decode");
        step(1, 1, 0, e_memadr(), "lw2_memadr");
        step(1, 0, 0, e_memrd(), "lw2_memrd_wait");
        step(1, 1, 0, e_memrd(), "lw2_memrd");
        step(1, 1, 0, e_memwb(), "lw2_memwb");

        // sw with 3 wait cycles: 7 cycles total.
        set_ir(6'b101011, 6'b000000);
        step(1, 1, 0, e_fetch(1), "sw_fetch");
        step(1, 1, 0, e_decode(0), "sw_decode");
        step(1, 1, 0, e_memadr(), "sw_memadr");
        step(1, 0, 0, e_memwr(), "sw_memwr_wait1");
        step(1, 0, 0, e_memwr(), "sw_memwr_wait2");
        step(1, 0, 0, e_memwr(), "sw_memwr_wait3");
        step(1, 1, 0, e_memwr(), "sw_memwr_ready");

        // sw with reset on the 2nd wait cycle: access dropped, no write.
        step(1, 1, 0, e_fetch(1), "swr_fetch");
        step(1, 1, 0, e_decode(0), "swr_decode");
        step(1, 1, 0, e_memadr(), "swr_memadr");
        step(1, 0, 0, e_memwr(), "swr_memwr_wait1");
        step(0, 0, 0, v(4'd5, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0),
             "swr_reset_in_memwr");

        // Illegal opcode: one-cycle pulse in DECODE, then FETCH.
        set_ir(6'b111111, 6'b000000);
        step(1, 1, 0, e_fetch(1), "ill_fetch_after_reset");
        step(1, 1, 0, e_decode(1), "ill_decode");
        set_ir(6'b000010, 6'b000000);
        step(1, 1, 0, e_fetch(1), "ill_next_fetch");
        step(1, 1, 0, e_decode(0), "ill_next_decode");
        step(1, 1, 0, e_jump(), "ill_next_jump");
        step(1, 1, 0, e_fetch(1), "final_fetch");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #3;
        end
        if (exp_q.size() > 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle MIPS datapath. It decodes opcode/funct from the instruction register and sequences each instruction through a Moore FSM. Every step drives the datapath's mux selects, register and memory enables, and ALU control. A request/ready handshake to the shared instruction/data memory lets accesses stall for any number of cycles.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; sampled on clk
- op  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current access this cycle
- mem_req  output  1  memory access requested
- memwrite  output  1  write enable to memory (qualified by mem_ready)
- iord  output  1  0: address=PC, 1: address=ALUOut
- irwrite  output  1  instruction register load
- pcen  output  1  PC register load
- pcsrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target
- alusrca  output  1  0 PC, 1 register A
- alusrcb  output  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
- alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- regdst  output  1  0 rt, 1 rd
- memtoreg  output  1  0 ALUOut, 1 Data
- regwrite  output  1  register file write enable
- illegal  output  1  one-cycle pulse on unsupported opcode
- state  output  4  current FSM state (debug)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXE, ADDIWB, JUMP.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, ALU add, pcsrc=00.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1: irwrite=1, pcen=1, next state DECODE.
- DECODE: alusrca=0, alusrcb=11, add. Next state by op:
  - 100011 lw / 101011 sw -> MEMADR
  - 000000 R-type -> EXECUTE
  - 000100 beq / 000101 bne -> BRANCH
  - 001000 addi -> ADDIEXE
  - 000010 j -> JUMP
  - any other op -> FETCH, with illegal=1 for that DECODE cycle
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. Holds until mem_ready, then FETCH.
- EXECUTE: alusrca=1, alusrcb=00, funct decode. Next ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01. Next FETCH.
  - beq: pcen=zero.
  - bne: pcen=~zero.
- ADDIEXE: alusrca=1, alusrcb=10, add. Next ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next FETCH.
- JUMP: pcsrc=10, pcen=1. Next FETCH.
- Funct decode, used in EXECUTE only:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - any other funct -> 010, with no illegal pulse
- Any output not listed for a state is 0.
- op and funct are read only in DECODE, EXECUTE, MEMADR and BRANCH. They are stable because irwrite is low there.

## Timing
- State register updates on rising clk. Outputs are combinational from state; pcen in BRANCH and irwrite/pcen in FETCH also depend on zero and mem_ready.
- Cycles per instruction with zero-wait memory (mem_ready tied 1):
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3; illegal 2.
- Each wait cycle (mem_ready=0 in FETCH, MEMRD or MEMWR) adds one cycle. Outputs are held constant while waiting.
- mem_ready is ignored in states with mem_req=0.
- Reset:
  - While reset=0 at a clk edge, the next state is FETCH.
  - During any cycle with reset=0, mem_req, memwrite, irwrite, pcen, regwrite and illegal are forced 0.
- Reset mid-access (e.g. in MEMWR with mem_ready=0) abandons the access. No write is signalled on that cycle.
- First fetch starts the cycle after reset returns to 1.

## Structure
- Shared package mips_ctrl_pkg contains:
  - the state enum (4-bit)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - funct constants
  - ALU control encodings
  - the 2-bit aluop enum: ADD, SUB, FUNCT
- Sub-module alu_decoder: combinational, aluop + funct -> alucontrol. It is reused by the single-cycle control unit.
- Top-level multicycle_controller contains the state register, next-state logic and output decode.

## Test plan
- Reset held low 3 cycles with mem_ready=1 -> state=FETCH, all enables 0. After release, the first cycle shows mem_req=1, irwrite=1, pcen=1.
- lw (op=100011), mem_ready=1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 and memtoreg=1 only in cycle 5, then FETCH.
- R-type sub (funct=100010) -> alucontrol=110 in EXECUTE; regwrite=1, regdst=1 in ALUWB. funct=101010 gives 111.
- beq with zero=1, then bne with zero=1 -> pcen=1, pcsrc=01 in the beq BRANCH cycle; pcen=0 in the bne BRANCH cycle.
- sw with mem_ready low 3 cycles in MEMWR -> mem_req and memwrite held 1 for 4 cycles, leaves on the ready cycle, total 7 cycles. Repeat with reset=0 on the 2nd wait cycle -> memwrite=0 that cycle, next state FETCH.
- op=111111 -> illegal=1 for exactly one cycle in DECODE, then FETCH. No regwrite, memwrite or pcen in between.
